// File: rtl/masked_hpc3_rand_feeder_if.sv
// Handshake bundle between the PRNG source, the feeder and the HPC3 multiplier pair.
// The feeder takes the slave view; the environment driving it takes the master view.
interface masked_hpc3_rand_feeder_if #(
  parameter int RAND_WIDTH = 32,
  parameter int Q_WIDTH    = 1
);
  logic [RAND_WIDTH-1:0] in_rand;
  logic                  in_rand_valid;
  logic                  out_rand_ready;
  logic                  in_flush;
  logic [Q_WIDTH-1:0]    out_r_ab;
  logic [Q_WIDTH-1:0]    out_p_ab;
  logic [Q_WIDTH-1:0]    out_p_ac;
  logic                  out_valid;
  logic                  in_ready;
  logic                  out_starved;

  modport master (
    output in_rand, in_rand_valid, in_flush, in_ready,
    input  out_rand_ready, out_r_ab, out_p_ab, out_p_ac, out_valid, out_starved
  );

  modport slave (
    input  in_rand, in_rand_valid, in_flush, in_ready,
    output out_rand_ready, out_r_ab, out_p_ab, out_p_ac, out_valid, out_starved
  );
endinterface

// File: rtl/masked_hpc3_rand_feeder.sv
// Bit-granular randomness buffer feeding one (r_ab, p_ab, p_ac) tuple per consumer handshake.
// Every PRNG bit leaves the buffer exactly once, oldest first, so no bit appears in two tuples.
module masked_hpc3_rand_feeder #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int RAND_WIDTH = 32
) (
  input logic                      in_clock,
  input logic                      in_reset,
  masked_hpc3_rand_feeder_if.slave bus
);
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int Q             = NUM_QUADRATIC * BIT_WIDTH;
  localparam int NEED          = 3 * Q;
  localparam int CAP           = 2 * RAND_WIDTH;
  localparam int FW            = $clog2(CAP + 1);

  localparam logic [FW-1:0] NEED_W    = FW'(NEED);
  localparam logic [FW-1:0] RW_W      = FW'(RAND_WIDTH);
  localparam logic [FW-1:0] READY_MAX = FW'(CAP - RAND_WIDTH);

  generate
    if (NEED > RAND_WIDTH) begin : g_bad_params
      $error("masked_hpc3_rand_feeder: one tuple needs more bits than a PRNG word provides");
    end
  endgenerate

  logic [CAP-1:0] buf_q, buf_d, base, word_ext, mask_ext;
  logic [FW-1:0]  fill_q, fill_d, pos;
  logic           starved_q, starved_d;
  logic           valid, ready, push, pop;

  assign valid = !in_reset && (fill_q >= NEED_W);
  assign ready = !in_reset && !bus.in_flush && (fill_q <= READY_MAX);
  assign push  = bus.in_rand_valid && ready;
  assign pop   = valid && bus.in_ready;

  assign word_ext = {{(CAP-RAND_WIDTH){1'b0}}, bus.in_rand};
  assign mask_ext = {{(CAP-RAND_WIDTH){1'b0}}, {RAND_WIDTH{1'b1}}};

  assign bus.out_valid      = valid;
  assign bus.out_rand_ready = ready;
  assign bus.out_r_ab       = buf_q[0 +: Q];
  assign bus.out_p_ab       = buf_q[Q +: Q];
  assign bus.out_p_ac       = buf_q[2*Q +: Q];
  assign bus.out_starved    = starved_q;

  // Pop shifts the oldest tuple out first; a same-cycle push then lands right after the survivors.
  always_comb begin
    base      = buf_q;
    pos       = fill_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    starved_d = bus.in_ready && !valid && !in_reset;
    if (bus.in_flush) begin
      buf_d  = '0;
      fill_d = '0;
    end else begin
      if (pop) begin
        base = buf_q >> NEED;
        pos  = fill_q - NEED_W;
      end
      buf_d  = base;
      fill_d = pos;
      if (push) begin
        buf_d  = (base & ~(mask_ext << pos)) | (word_ext << pos);
        fill_d = pos + RW_W;
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      buf_q     <= '0;
      fill_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      starved_q <= starved_d;
    end
  end
endmodule

// File: tb/tb_masked_hpc3_rand_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-queue model.
module tb_masked_hpc3_rand_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit   mq[$];
  logic exp_starved = 1'b0;

  always #5 clk = ~clk;

  masked_hpc3_rand_feeder_if #(.RAND_WIDTH(8), .Q_WIDTH(1)) bus ();

  masked_hpc3_rand_feeder #(
    .NUM_SHARES(2),
    .BIT_WIDTH (1),
    .RAND_WIDTH(8)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .bus     (bus)
  );

  // Model view: the buffer is just a FIFO of bits, oldest at index 0.
  function automatic logic m_valid();
    return !rst && (mq.size() >= 3);
  endfunction

  function automatic logic m_ready();
    return !rst && !bus.in_flush && (mq.size() <= 8);
  endfunction

  function automatic logic m_bit(input int i);
    return (i < mq.size()) ? logic'(mq[i]) : 1'b0;
  endfunction

  task automatic apply(input logic r, input logic v, input logic [7:0] w,
                       input logic f, input logic rd);
    @(negedge clk);
    rst               = r;
    bus.in_rand_valid = v;
    bus.in_rand       = w;
    bus.in_flush      = f;
    bus.in_ready      = rd;
    #1;
  endtask

  task automatic tick();
    bit         ev_push, ev_pop;
    logic       st;
    logic [7:0] w;
    ev_push = bus.in_rand_valid && m_ready();
    ev_pop  = m_valid() && bus.in_ready;
    st      = bus.in_ready && !m_valid() && !rst;
    w       = bus.in_rand;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_starved = 1'b0;
    end else begin
      if (bus.in_flush) mq.delete();
      else begin
        if (ev_pop) repeat (3) void'(mq.pop_front());
        if (ev_push) for (int i = 0; i < 8; i++) mq.push_back(w[i]);
      end
      exp_starved = st;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 8'hA5, 0, 1);
    checks++; if (bus.out_rand_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b want 0", bus.out_rand_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", bus.out_valid); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd0) begin errors++; $display("[TB] FAIL reset_fill got %0d want 0", dut.fill_q); end
    checks++; if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 3'b000) begin errors++; $display("[TB] FAIL reset_tuple got %b want 000", {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
    checks++; if (bus.out_starved !== 1'b0) begin errors++; $display("[TB] FAIL reset_starved got %0b want 0", bus.out_starved); end
    checks++; if (bus.out_rand_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after got %0b want 1", bus.out_rand_ready); end
  endtask

  task automatic test_push_pop();
    apply(0, 1, 8'hB5, 0, 0); tick();
    apply(0, 0, 8'h00, 0, 1);
    checks++; if (dut.fill_q !== 5'd8) begin errors++; $display("[TB] FAIL pp_fill8 got %0d want 8", dut.fill_q); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pp_valid got %0b want 1", bus.out_valid); end
    checks++; if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 3'b101) begin errors++; $display("[TB] FAIL pp_tuple1 got %b want 101", {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
    tick();
    apply(0, 0, 8'h00, 0, 1);
    checks++; if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 3'b011) begin errors++; $display("[TB] FAIL pp_tuple2 got %b want 011", {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
    checks++; if (dut.fill_q !== 5'd5) begin errors++; $display("[TB] FAIL pp_fill5 got %0d want 5", dut.fill_q); end
    tick();
    apply(0, 0, 8'h00, 0, 1);
    checks++; if (dut.fill_q !== 5'd2) begin errors++; $display("[TB] FAIL pp_fill2 got %0d want 2", dut.fill_q); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pp_valid_low got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_starved !== 1'b0) begin errors++; $display("[TB] FAIL pp_starved_pre got %0b want 0", bus.out_starved); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (bus.out_starved !== 1'b1) begin errors++; $display("[TB] FAIL pp_starved_pulse got %0b want 1", bus.out_starved); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (bus.out_starved !== 1'b0) begin errors++; $display("[TB] FAIL pp_starved_end got %0b want 0", bus.out_starved); end
    apply(0, 1, 8'h00, 0, 0); tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd10) begin errors++; $display("[TB] FAIL pp_fill10 got %0d want 10", dut.fill_q); end
    checks++; if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 3'b010) begin errors++; $display("[TB] FAIL pp_tuple3 got %b want 010", {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
  endtask

  task automatic test_backpressure();
    apply(1, 0, 8'h00, 0, 0); tick();
    apply(0, 1, 8'hFF, 0, 0);
    checks++; if (bus.out_rand_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready0 got %0b want 1", bus.out_rand_ready); end
    tick();
    apply(0, 1, 8'h0F, 0, 0);
    checks++; if (dut.fill_q !== 5'd8) begin errors++; $display("[TB] FAIL bp_fill8 got %0d want 8", dut.fill_q); end
    checks++; if (bus.out_rand_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready8 got %0b want 1", bus.out_rand_ready); end
    tick();
    apply(0, 1, 8'hAA, 0, 1);
    checks++; if (dut.fill_q !== 5'd16) begin errors++; $display("[TB] FAIL bp_fill16 got %0d want 16", dut.fill_q); end
    checks++; if (bus.out_rand_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready16 got %0b want 0", bus.out_rand_ready); end
    tick();
    apply(0, 1, 8'hAA, 0, 1);
    checks++; if (dut.fill_q !== 5'd13) begin errors++; $display("[TB] FAIL bp_fill13 got %0d want 13", dut.fill_q); end
    checks++; if (bus.out_rand_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready13 got %0b want 0", bus.out_rand_ready); end
    tick();
    apply(0, 1, 8'hAA, 0, 1);
    checks++; if (dut.fill_q !== 5'd10) begin errors++; $display("[TB] FAIL bp_fill10 got %0d want 10", dut.fill_q); end
    checks++; if (bus.out_rand_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready10 got %0b want 0", bus.out_rand_ready); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd7) begin errors++; $display("[TB] FAIL bp_fill7 got %0d want 7", dut.fill_q); end
    checks++; if (bus.out_rand_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready7 got %0b want 1", bus.out_rand_ready); end
  endtask

  task automatic test_back_to_back();
    apply(1, 0, 8'h00, 0, 0); tick();
    apply(0, 1, 8'hB5, 0, 0); tick();
    apply(0, 1, 8'h3C, 0, 1);
    checks++; if ({bus.out_valid, bus.out_rand_ready} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_handshake got %b want 11", {bus.out_valid, bus.out_rand_ready}); end
    checks++; if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 3'b101) begin errors++; $display("[TB] FAIL b2b_tuple got %b want 101", {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd13) begin errors++; $display("[TB] FAIL b2b_fill got %0d want 13", dut.fill_q); end
    checks++; if (dut.buf_q[12:0] !== {8'h3C, 5'b10110}) begin errors++; $display("[TB] FAIL b2b_buf got %h want %h", dut.buf_q[12:0], {8'h3C, 5'b10110}); end
  endtask

  task automatic test_flush_and_reset();
    apply(0, 1, 8'hFF, 1, 1);
    checks++; if (bus.out_rand_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_ready got %0b want 0", bus.out_rand_ready); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd0) begin errors++; $display("[TB] FAIL fl_fill got %0d want 0", dut.fill_q); end
    checks++; if ({bus.out_valid, bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 4'b0000) begin errors++; $display("[TB] FAIL fl_outs got %b want 0000", {bus.out_valid, bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
    apply(0, 1, 8'hB5, 0, 0); tick();
    apply(0, 1, 8'h3C, 0, 1); tick();
    apply(1, 1, 8'hFF, 0, 1);
    checks++; if ({bus.out_rand_ready, bus.out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rs_hs got %b want 00", {bus.out_rand_ready, bus.out_valid}); end
    tick();
    apply(0, 0, 8'h00, 0, 0);
    checks++; if (dut.fill_q !== 5'd0) begin errors++; $display("[TB] FAIL rs_fill got %0d want 0", dut.fill_q); end
    checks++; if ({bus.out_valid, bus.out_starved, bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== 5'b00000) begin errors++; $display("[TB] FAIL rs_outs got %b want 00000", {bus.out_valid, bus.out_starved, bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}); end
  endtask

  task automatic test_random();
    apply(1, 0, 8'h00, 0, 0); tick();
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 8'($urandom()),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
      checks++; if (bus.out_rand_ready !== m_ready()) begin errors++; $display("[TB] FAIL rnd_ready n=%0d got %0b want %0b", n, bus.out_rand_ready, m_ready()); end
      checks++; if (bus.out_valid !== m_valid()) begin errors++; $display("[TB] FAIL rnd_valid n=%0d got %0b want %0b", n, bus.out_valid, m_valid()); end
      checks++; if (int'(dut.fill_q) !== mq.size()) begin errors++; $display("[TB] FAIL rnd_fill n=%0d got %0d want %0d", n, dut.fill_q, mq.size()); end
      checks++; if (dut.fill_q > 5'd16) begin errors++; $display("[TB] FAIL rnd_overflow n=%0d got %0d want <=16", n, dut.fill_q); end
      checks++; if (bus.out_starved !== exp_starved) begin errors++; $display("[TB] FAIL rnd_starved n=%0d got %0b want %0b", n, bus.out_starved, exp_starved); end
      if (m_valid()) begin
        checks++;
        if ({bus.out_r_ab, bus.out_p_ab, bus.out_p_ac} !== {m_bit(0), m_bit(1), m_bit(2)}) begin
          errors++;
          $display("[TB] FAIL rnd_tuple n=%0d got %b want %b", n, {bus.out_r_ab, bus.out_p_ab, bus.out_p_ac}, {m_bit(0), m_bit(1), m_bit(2)});
        end
      end
      tick();
    end
  endtask

  initial begin
    bus.in_rand       = '0;
    bus.in_rand_valid = 1'b0;
    bus.in_flush      = 1'b0;
    bus.in_ready      = 1'b0;
    test_reset();
    test_push_pop();
    test_backpressure();
    test_back_to_back();
    test_flush_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] simulation did not finish in time");
  end
endmodule
